// File: rtl/alu_pkg.sv
//==== alu_pkg : encodings shared between the ALU pre-processor and the ALU -- rev 1.0 ====
`default_nettype none

package alu_pkg;

  typedef enum logic [2:0] {
    OPSEL_SHIFT_REG   = 3'b000,
    OPSEL_ARITH_LOGIC = 3'b001,
    OPSEL_MEM_WRITE   = 3'b100,
    OPSEL_MEM_READ    = 3'b101
  } opsel_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_XOR = 3'b100,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef enum logic [2:0] {
    LD_BYTE = 3'b000,
    LD_HALF = 3'b001,
    LD_WORD = 3'b010
  } ld_op_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ISSUE    = 2'b10
  } state_e;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage

`default_nettype wire

// File: rtl/alu_preproc_decode.sv
//==== alu_preproc_decode : instruction field split and immediate sign extension -- rev 1.0 ====
`default_nettype none

module alu_preproc_decode
  import alu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  opselect,
  output logic [2:0]  operation,
  output logic        imm_sel,
  output logic [31:0] imm_sext
);

  logic unused_bits;

  assign opselect    = instr[31:29];
  assign operation   = instr[28:26];
  assign imm_sel     = instr[25];
  assign imm_sext    = sext16(instr[15:0]);
  assign unused_bits = ^instr[24:16];

endmodule

`default_nettype wire

// File: rtl/alu_preproc.sv
//==== alu_preproc : operand fetch / issue stage ahead of the ALU; option ALU_PREPROC_TIMEOUT_EN -- rev 1.0 ====
`default_nettype none

module alu_preproc
  import alu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               instr_valid,
  output logic               instr_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        src1,
  input  logic [31:0]        src2,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        mem_rdata,
  input  logic               mem_rdata_valid,
  output logic signed [31:0] aluin1,
  output logic signed [31:0] aluin2,
  output logic [2:0]         aluoperation,
  output logic [2:0]         aluopselect,
  output logic               enable,
`ifdef ALU_PREPROC_TIMEOUT_EN
  output logic               timeout_err,
`endif
  output logic               drop
);

  state_e      state;
  logic [2:0]  dec_opselect;
  logic [2:0]  dec_operation;
  logic        dec_imm_sel;
  logic [31:0] dec_imm_sext;
  // Load opcode fields are parked here so the ALU-facing outputs hold until issue.
  logic [2:0]  pend_operation;
  logic [2:0]  pend_opselect;

  alu_preproc_decode u_decode (
    .instr     (instr),
    .opselect  (dec_opselect),
    .operation (dec_operation),
    .imm_sel   (dec_imm_sel),
    .imm_sext  (dec_imm_sext)
  );

  assign instr_ready = (state == ST_IDLE);
  assign enable      = (state == ST_ISSUE);

`ifdef ALU_PREPROC_TIMEOUT_EN
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  logic [CNT_W-1:0] wait_cnt;
`else
  localparam int unused_timeout = MEM_TIMEOUT;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      mem_req        <= 1'b0;
      drop           <= 1'b0;
      mem_addr       <= '0;
      aluin1         <= '0;
      aluin2         <= '0;
      aluoperation   <= '0;
      aluopselect    <= '0;
      pend_operation <= '0;
      pend_opselect  <= '0;
`ifdef ALU_PREPROC_TIMEOUT_EN
      wait_cnt       <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      mem_req <= 1'b0;
      drop    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (instr_valid) begin
            case (dec_opselect)
              OPSEL_ARITH_LOGIC: begin
                aluin1       <= src1;
                aluin2       <= dec_imm_sel ? dec_imm_sext : src2;
                aluoperation <= dec_operation;
                aluopselect  <= dec_opselect;
                state        <= ST_ISSUE;
              end
              OPSEL_MEM_READ: begin
                mem_req        <= 1'b1;
                mem_addr       <= src1 + dec_imm_sext;
                pend_operation <= dec_operation;
                pend_opselect  <= dec_opselect;
                state          <= ST_MEM_WAIT;
`ifdef ALU_PREPROC_TIMEOUT_EN
                wait_cnt       <= '0;
`endif
              end
              default: drop <= 1'b1;
            endcase
          end
        end
        ST_MEM_WAIT: begin
          if (mem_rdata_valid) begin
            aluin1       <= mem_addr;
            aluin2       <= mem_rdata;
            aluoperation <= pend_operation;
            aluopselect  <= pend_opselect;
            state        <= ST_ISSUE;
          end
`ifdef ALU_PREPROC_TIMEOUT_EN
          else if (wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
            aluin1       <= mem_addr;
            aluin2       <= '0;
            aluoperation <= pend_operation;
            aluopselect  <= pend_opselect;
            timeout_err  <= 1'b1;
            state        <= ST_ISSUE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
`endif
        end
        ST_ISSUE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_alu_preproc.sv
//==== tb_alu_preproc : directed self-checking bench for alu_preproc -- rev 1.0 ====
`default_nettype none

module tb_alu_preproc;
  import alu_pkg::*;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               instr_valid = 1'b0;
  logic               instr_ready;
  logic [31:0]        instr = '0;
  logic [31:0]        src1 = '0;
  logic [31:0]        src2 = '0;
  logic               mem_req;
  logic [31:0]        mem_addr;
  logic [31:0]        mem_rdata = '0;
  logic               mem_rdata_valid = 1'b0;
  logic signed [31:0] aluin1;
  logic signed [31:0] aluin2;
  logic [2:0]         aluoperation;
  logic [2:0]         aluopselect;
  logic               enable;
  logic               drop;
`ifdef ALU_PREPROC_TIMEOUT_EN
  logic               timeout_err;
`endif

  int errors = 0;
  int checks = 0;

  alu_preproc #(.MEM_TIMEOUT(16)) dut (
    .clock           (clk),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .src1            (src1),
    .src2            (src2),
    .mem_req         (mem_req),
    .mem_addr        (mem_addr),
    .mem_rdata       (mem_rdata),
    .mem_rdata_valid (mem_rdata_valid),
    .aluin1          (aluin1),
    .aluin2          (aluin2),
    .aluoperation    (aluoperation),
    .aluopselect     (aluopselect),
    .enable          (enable),
`ifdef ALU_PREPROC_TIMEOUT_EN
    .timeout_err     (timeout_err),
`endif
    .drop            (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] sel, input logic [2:0] op,
                                     input logic isel, input logic [15:0] imm);
    return {sel, op, isel, 9'd0, imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL reset_enable: got %b expected 0", enable); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop: got %b expected 0", drop); end
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", instr_ready); end
    checks++; if ({aluin1, aluin2, mem_addr} !== 96'd0) begin errors++; $display("FAIL reset_data: got %h %h %h expected zeros", aluin1, aluin2, mem_addr); end
    checks++; if ({aluoperation, aluopselect} !== 6'd0) begin errors++; $display("FAIL reset_ops: got %b %b expected 000 000", aluoperation, aluopselect); end
`ifdef ALU_PREPROC_TIMEOUT_EN
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout_err: got %b expected 0", timeout_err); end
`endif
    reset = 1'b0;
  endtask

  task automatic test_add();
    instr = mk(OPSEL_ARITH_LOGIC, ALU_ADD, 1'b0, 16'h1234); src1 = 32'd5; src2 = 32'd7;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0; src1 = 32'd99; src2 = 32'd99;
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL add_enable: got %b expected 1", enable); end
    checks++; if (aluin1 !== 32'sd5) begin errors++; $display("FAIL add_aluin1: got %h expected 5", aluin1); end
    checks++; if (aluin2 !== 32'sd7) begin errors++; $display("FAIL add_aluin2: got %h expected 7", aluin2); end
    checks++; if ({aluopselect, aluoperation} !== 6'b001_000) begin errors++; $display("FAIL add_ops: got %b %b expected 001 000", aluopselect, aluoperation); end
    tick();
    checks++; if (enable !== 1'b0) begin errors++; $display("FAIL add_enable_one_cycle: got %b expected 0", enable); end
    checks++; if (aluin1 !== 32'sd5 || aluin2 !== 32'sd7) begin errors++; $display("FAIL add_hold: got %h %h expected 5 7", aluin1, aluin2); end
  endtask

  task automatic test_sub_imm();
    instr = mk(OPSEL_ARITH_LOGIC, ALU_SUB, 1'b1, 16'hFFFE); src1 = 32'd10; src2 = 32'd123;
    checks++; if (instr_ready !== 1'b1) begin errors++; $display("FAIL sub_ready_before: got %b expected 1", instr_ready); end
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (instr_ready !== 1'b0 || enable !== 1'b1) begin errors++; $display("FAIL sub_issue: got ready=%b enable=%b expected ready=0 enable=1", instr_ready, enable); end
    checks++; if (aluin2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_aluin2: got %h expected fffffffe", aluin2); end
    checks++; if (aluin1 !== 32'sd10 || aluoperation !== 3'b001) begin errors++; $display("FAIL sub_aluin1_op: got %h %b expected a 001", aluin1, aluoperation); end
    tick();
    checks++; if (instr_ready !== 1'b1 || enable !== 1'b0) begin errors++; $display("FAIL sub_after: got ready=%b enable=%b expected ready=1 enable=0", instr_ready, enable); end
  endtask

  task automatic test_mem_read();
    instr = mk(OPSEL_MEM_READ, LD_BYTE, 1'b0, 16'h0004); src1 = 32'h100; src2 = 32'h0;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL mr_req: got %b expected 1", mem_req); end
    checks++; if (mem_addr !== 32'h104) begin errors++; $display("FAIL mr_addr: got %h expected 104", mem_addr); end
    checks++; if (enable !== 1'b0 || instr_ready !== 1'b0) begin errors++; $display("FAIL mr_wait: got enable=%b ready=%b expected 0 0", enable, instr_ready); end
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL mr_req_pulse: got %b expected 0", mem_req); end
    tick();
    checks++; if (enable !== 1'b0 || aluin2 !== 32'hFFFFFFFE) begin errors++; $display("FAIL mr_hold: got enable=%b aluin2=%h expected 0 fffffffe", enable, aluin2); end
    mem_rdata = 32'h000000F0; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0; mem_rdata = 32'hDEADBEEF;
    checks++; if (enable !== 1'b1) begin errors++; $display("FAIL mr_enable: got %b expected 1", enable); end
    checks++; if (aluin2 !== 32'h000000F0 || aluin1 !== 32'h104) begin errors++; $display("FAIL mr_operands: got %h %h expected 104 f0", aluin1, aluin2); end
    checks++; if ({aluopselect, aluoperation} !== 6'b101_000) begin errors++; $display("FAIL mr_ops: got %b %b expected 101 000", aluopselect, aluoperation); end
    tick();
    checks++; if (enable !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL mr_done: got enable=%b ready=%b expected 0 1", enable, instr_ready); end
  endtask

  task automatic test_drop();
    logic [2:0] sels [4];
    sels[0] = OPSEL_MEM_WRITE; sels[1] = OPSEL_SHIFT_REG; sels[2] = 3'b111; sels[3] = 3'b010;
    for (int i = 0; i < 4; i++) begin
      instr = mk(sels[i], 3'b000, 1'b0, 16'h0008); src1 = 32'h200;
      instr_valid = 1'b1;
      tick();
      instr_valid = 1'b0;
      checks++; if (drop !== 1'b1) begin errors++; $display("FAIL drop_pulse[%0d]: got %b expected 1", i, drop); end
      checks++; if (enable !== 1'b0 || mem_req !== 1'b0 || instr_ready !== 1'b1) begin errors++; $display("FAIL drop_side[%0d]: got enable=%b req=%b ready=%b expected 0 0 1", i, enable, mem_req, instr_ready); end
      tick();
      checks++; if (drop !== 1'b0 || enable !== 1'b0) begin errors++; $display("FAIL drop_end[%0d]: got drop=%b enable=%b expected 0 0", i, drop, enable); end
    end
    // Stray load data while idle must not issue anything.
    mem_rdata = 32'h55; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    tick();
    checks++; if (enable !== 1'b0 || aluin2 !== 32'h000000F0) begin errors++; $display("FAIL idle_rdata: got enable=%b aluin2=%h expected 0 f0", enable, aluin2); end
  endtask

  task automatic test_back_to_back();
    instr = mk(OPSEL_ARITH_LOGIC, ALU_ADD, 1'b0, 16'h0); src1 = 32'd1; src2 = 32'd2;
    instr_valid = 1'b1;
    tick();
    checks++; if (enable !== 1'b1 || aluin1 !== 32'sd1 || aluin2 !== 32'sd2) begin errors++; $display("FAIL b2b_first: got enable=%b %h %h expected 1 1 2", enable, aluin1, aluin2); end
    instr = mk(OPSEL_ARITH_LOGIC, ALU_XOR, 1'b1, 16'h8000); src1 = 32'd3; src2 = 32'd4;
    tick();
    checks++; if (enable !== 1'b0 || instr_ready !== 1'b1 || aluin1 !== 32'sd1) begin errors++; $display("FAIL b2b_gap: got enable=%b ready=%b aluin1=%h expected 0 1 1", enable, instr_ready, aluin1); end
    tick();
    instr_valid = 1'b0;
    checks++; if (enable !== 1'b1 || aluin1 !== 32'sd3 || aluin2 !== 32'hFFFF8000 || aluoperation !== 3'b100) begin errors++; $display("FAIL b2b_second: got enable=%b %h %h %b expected 1 3 ffff8000 100", enable, aluin1, aluin2, aluoperation); end
    tick();
  endtask

  task automatic test_reset_mem_wait();
    instr = mk(OPSEL_MEM_READ, LD_WORD, 1'b0, 16'hFFFC); src1 = 32'h40;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    checks++; if (mem_addr !== 32'h3C || mem_req !== 1'b1) begin errors++; $display("FAIL rmw_addr: got %h req=%b expected 3c 1", mem_addr, mem_req); end
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mem_rdata = 32'h77; mem_rdata_valid = 1'b1;
    tick();
    mem_rdata_valid = 1'b0;
    checks++; if (enable !== 1'b0 || instr_ready !== 1'b1 || mem_addr !== 32'h0) begin errors++; $display("FAIL rmw_abandon: got enable=%b ready=%b addr=%h expected 0 1 0", enable, instr_ready, mem_addr); end
    tick();
    checks++; if (enable !== 1'b0 || aluin2 !== 32'h0) begin errors++; $display("FAIL rmw_late: got enable=%b aluin2=%h expected 0 0", enable, aluin2); end
  endtask

`ifdef ALU_PREPROC_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    instr = mk(OPSEL_MEM_READ, LD_HALF, 1'b0, 16'h0010); src1 = 32'h1000;
    instr_valid = 1'b1;
    tick();
    instr_valid = 1'b0;
    n = 0;
    while (enable !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL to_latency: got %0d expected 16", n); end
    checks++; if (aluin2 !== 32'h0 || aluin1 !== 32'h1010 || timeout_err !== 1'b1) begin errors++; $display("FAIL to_issue: got %h %h err=%b expected 1010 0 1", aluin1, aluin2, timeout_err); end
    tick(); tick();
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky: got %b expected 1", timeout_err); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_clear: got %b expected 0", timeout_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_add();
    test_sub_imm();
    test_mem_read();
    test_drop();
    test_back_to_back();
    test_reset_mem_wait();
`ifdef ALU_PREPROC_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
